multi_tick_gen: RTL

//  Parametrised multi-channel tick generator; successor to the fixed-period single-channel delay.
//  - NUM_CH independent counters, each with a runtime-programmable period and a periodic/one-shot mode.
//  - Each emits one-cycle tick pulses that pace UART timing brute-force sequencing and other timed FSMs.

---
 rtl/multi_tick_gen.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: NUM_CH independent tick generators. Each channel has a
// runtime-programmable period and a periodic/one-shot mode. Each channel emits
// registered one-cycle tick pulses for pacing timed FSMs.
// Optional feature macro: TICK_CNT_EN adds a 16-bit per-channel tick counter
// output (tick_cnt).
//
// Config handshake: cfg_we is a single-cycle strobe with no ready. A write is
// always accepted on the edge where cfg_we is sampled high. A valid cfg_ch
// updates that channel's shadow period/mode. An invalid cfg_ch changes nothing
// and raises cfg_err for exactly the following cycle.
module multi_tick_gen #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 27,
    parameter int unsigned DEF_PERIOD = CLK_HZ / 15,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
`ifdef TICK_CNT_EN
    ,
    output logic [NUM_CH*16-1:0] tick_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_t;

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);

    // Zero-extended channel select so the range check never truncates NUM_CH.
    logic [CH_W:0] cfg_ch_x;
    logic          cfg_valid;

    assign cfg_ch_x  = {1'b0, cfg_ch};
    assign cfg_valid = (cfg_ch_x < (CH_W+1)'(NUM_CH));

    // Flag a write to a channel that does not exist for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_valid;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t        state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] per_q;
        logic [CNT_W-1:0] shd_per_q;
        logic             os_q;
        logic             shd_os_q;
        logic             tick_q;
        logic             busy_q;
        logic             wr;
        logic             wrap;
        logic             tick_set;

        assign wr       = cfg_we && (cfg_ch_x == (CH_W+1)'(i));
        // The last count of a period is P-1. This avoids any overflow path.
        assign wrap     = (cnt_q == per_q - CNT_W'(1));
        assign tick_set = en[i] && (state_q == ST_RUN) && wrap;

        // Per-channel FSM (IDLE -> RUN -> DONE) with a shadowed period/mode.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                per_q     <= DEF_P;
                shd_per_q <= DEF_P;
                os_q      <= 1'b0;
                shd_os_q  <= 1'b0;
                tick_q    <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (wr) begin
                    shd_per_q <= cfg_period;
                    shd_os_q  <= cfg_oneshot;
                end
                if (!en[i]) begin
                    // Disabling a channel wins over a coinciding wrap.
                    // A pending shadow value becomes active immediately.
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    per_q   <= wr ? cfg_period  : shd_per_q;
                    os_q    <= wr ? cfg_oneshot : shd_os_q;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (wr) begin
                                per_q <= cfg_period;
                                os_q  <= cfg_oneshot;
                            end
                            if (per_q != '0) begin
                                state_q <= ST_RUN;
                                cnt_q   <= '0;
                                busy_q  <= 1'b1;
                            end
                        end
                        ST_RUN: begin
                            if (wrap) begin
                                // The shadow is read before this edge's write,
                                // so a write landing on a tick edge waits one period.
                                tick_q <= 1'b1;
                                cnt_q  <= '0;
                                per_q  <= shd_per_q;
                                os_q   <= shd_os_q;
                                if (os_q) begin
                                    state_q <= ST_DONE;
                                    busy_q  <= 1'b0;
                                end else if (shd_per_q == '0) begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                        ST_DONE: begin
                            if (wr) begin
                                per_q <= cfg_period;
                                os_q  <= cfg_oneshot;
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign tick[i] = tick_q;
        assign busy[i] = busy_q;

`ifdef TICK_CNT_EN
        logic [15:0] tcnt_q;

        // Count issued ticks. A valid config write to this channel restarts the count.
        always_ff @(posedge clk) begin
            if (rst || wr) begin
                tcnt_q <= '0;
            end else if (tick_set) begin
                tcnt_q <= tcnt_q + 16'd1;
            end
        end

        assign tick_cnt[i*16 +: 16] = tcnt_q;
`else
        // The tick-raise condition is only consumed by the optional counter.
        logic unused_tick_set;
        assign unused_tick_set = tick_set;
`endif
    end

endmodule
